// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between NREQ requesting engines and the shared-ALU arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_a;
   logic [NREQ*8-1:0] req_b;
   logic [NREQ*4-1:0] req_op;
   logic              resp_valid;
   logic              resp_ready;
   logic [7:0]        resp_data;
   logic              resp_carry;
   logic              resp_err;
   logic [IDW-1:0]    resp_id;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_carry, resp_err, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_carry, resp_err, resp_id
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit combinational ALU among NREQ requesters, registered response.
// Optional ALU_ARB_ILLEGAL_OP_EN: ops 4'hE/4'hF are answered with an error instead of executing as add.
module alu_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   alu_rr_arbiter_if.slave   bus
);
   localparam int DATA_W = 8;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state;
   logic [IDW-1:0]    ptr;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    gnt_idx;
   logic              found;
   logic              can_accept;
   logic              accept;
   logic [IDW-1:0]    ptr_next;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [3:0]        op_sel;
   logic [9:0]        alu_res;

   // Returns {err, carry, data}; carry only meaningful for add, divide-by-zero overrides the ALU.
   function automatic logic [9:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
      logic [8:0]  sum;
      logic [15:0] prod;
      logic [7:0]  data;
      logic        carry;
      logic        err;
      sum   = {1'b0, a} + {1'b0, b};
      prod  = a * b;
      data  = sum[7:0];
      carry = 1'b0;
      err   = 1'b0;
      case (sel)
         4'h0: begin data = sum[7:0]; carry = sum[8]; end
         4'h1: data = a - b;
         4'h2: data = prod[7:0];
         4'h3: begin
            if (b == 8'h00) begin
               data = 8'hFF;
               err  = 1'b1;
            end else begin
               data = a / b;
            end
         end
         4'h4: data = {a[6:0], 1'b0};
         4'h5: data = {1'b0, a[7:1]};
         4'h6: data = {a[6:0], a[7]};
         4'h7: data = {a[0], a[7:1]};
         4'h8: data = a & b;
         4'h9: data = a | b;
         4'hA: data = a ^ b;
         4'hB: data = ~(a | b);
         4'hC: data = ~(a & b);
         4'hD: data = ~(a ^ b);
`ifdef ALU_ARB_ILLEGAL_OP_EN
         4'hE, 4'hF: begin data = 8'h00; err = 1'b1; end
`endif
         default: data = sum[7:0];
      endcase
      return {err, carry, data};
   endfunction

   // Search req_valid starting at ptr, wrapping modulo NREQ; first hit wins.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gnt_idx    = IDW'(idx);
         end
      end
   end

   assign can_accept    = (state == EMPTY) || bus.resp_ready;
   assign bus.req_ready = (can_accept && !rst) ? grant : '0;
   assign accept        = |bus.req_ready;
   assign ptr_next      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      op_a    = bus.req_a[DATA_W*int'(gnt_idx) +: DATA_W];
      op_b    = bus.req_b[DATA_W*int'(gnt_idx) +: DATA_W];
      op_sel  = bus.req_op[4*int'(gnt_idx) +: 4];
      alu_res = alu_eval(op_a, op_b, op_sel);
   end

   // Response register: loaded on accept, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= EMPTY;
         ptr            <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_carry <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_id    <= '0;
      end else begin
         case (state)
            EMPTY:   if (accept) state <= FULL;
            FULL:    if (bus.resp_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         bus.resp_valid <= accept || ((state == FULL) && !bus.resp_ready);
         if (accept) begin
            ptr            <= ptr_next;
            bus.resp_data  <= alu_res[7:0];
            bus.resp_carry <= alu_res[8];
            bus.resp_err   <= alu_res[9];
            bus.resp_id    <= gnt_idx;
         end
      end
   end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (4 requesters); honours ALU_ARB_ILLEGAL_OP_EN.
module tb_alu_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_rr_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

   alu_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op);
      bus.req_a[i*8 +: 8]  = a;
      bus.req_b[i*8 +: 8]  = b;
      bus.req_op[i*4 +: 4] = op;
   endtask

   task automatic test_reset;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.resp_ready = 1'b0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 4'hF;
      #1;
      checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
      checks++; if ({bus.resp_data, bus.resp_carry, bus.resp_err, bus.resp_id} !== 12'h000) begin
         errors++; $display("FAIL reset_resp_fields: got data=%h carry=%b err=%b id=%0d expected all 0",
                            bus.resp_data, bus.resp_carry, bus.resp_err, bus.resp_id); end
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_op;
      set_req(0, 8'hF0, 8'h20, 4'h0);
      bus.req_valid  = 4'b0001;
      bus.resp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", bus.resp_valid); end
      checks++; if (bus.resp_data !== 8'h10) begin errors++; $display("FAIL single_data: got %h expected 10", bus.resp_data); end
      checks++; if (bus.resp_carry !== 1'b1) begin errors++; $display("FAIL single_carry: got %b expected 1", bus.resp_carry); end
      checks++; if (bus.resp_id !== 2'd0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL single_id_err: got id=%0d err=%b expected id=0 err=0", bus.resp_id, bus.resp_err); end
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus.resp_valid); end
   endtask

   task automatic test_round_robin;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h10, 4'h0);
      bus.resp_ready = 1'b1;
      bus.req_valid  = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++; if (bus.req_ready !== 4'(1 << (k % 4))) begin
            errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, 4'(1 << (k % 4))); end
         if (k > 0) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'((k - 1) % 4) ||
                          bus.resp_data !== 8'(8'h11 + (k - 1) % 4)) begin
               errors++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
                                  k, bus.resp_valid, bus.resp_id, bus.resp_data, (k - 1) % 4, 8'(8'h11 + (k - 1) % 4)); end
         end
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      checks++; if (bus.resp_id !== 2'd3 || bus.resp_data !== 8'h14) begin
         errors++; $display("FAIL rr_last: got id=%0d data=%h expected id=3 data=14", bus.resp_id, bus.resp_data); end
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", bus.resp_valid); end
   endtask

   task automatic test_backpressure;
      set_req(2, 8'h05, 8'h03, 4'h1);
      bus.req_valid  = 4'b0100;
      bus.resp_ready = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant: got %b expected 0100", bus.req_ready); end
      @(posedge clk); #1;
      set_req(1, 8'h0F, 8'hF0, 4'h9);
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'h02 || bus.resp_id !== 2'd2 || bus.resp_err !== 1'b0) begin
            errors++; $display("FAIL bp_stable[%0d]: got v=%b data=%h id=%0d err=%b expected v=1 data=02 id=2 err=0",
                               k, bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_err); end
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_grant: got %b expected 0010", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'hFF || bus.resp_id !== 2'd1) begin
         errors++; $display("FAIL bp_next_resp: got v=%b data=%h id=%0d expected v=1 data=ff id=1",
                            bus.resp_valid, bus.resp_data, bus.resp_id); end
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.resp_valid); end
   endtask

   task automatic test_alu_ops;
      logic [3:0] vop [6];
      logic [7:0] va  [6];
      logic [7:0] vb  [6];
      logic [7:0] vd  [6];
      logic       vc  [6];
      logic       ve  [6];
      vop = '{4'h3,  4'h3,  4'h2,  4'h4,  4'h1,  4'h0};
      va  = '{8'h64, 8'h64, 8'h10, 8'h81, 8'h00, 8'hFF};
      vb  = '{8'h00, 8'h07, 8'h11, 8'h00, 8'h01, 8'h01};
      vd  = '{8'hFF, 8'h0E, 8'h10, 8'h02, 8'hFF, 8'h00};
      vc  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
      ve  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_req(0, va[k], vb[k], vop[k]);
         bus.req_valid = 4'b0001;
         #1;
         checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL op_grant[%0d]: got %b expected 0001", k, bus.req_ready); end
         @(posedge clk); #1;
         bus.req_valid = '0;
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== vd[k] || bus.resp_carry !== vc[k] ||
                       bus.resp_err !== ve[k] || bus.resp_id !== 2'd0) begin
            errors++; $display("FAIL op_resp[%0d]: got v=%b data=%h carry=%b err=%b id=%0d expected v=1 data=%h carry=%b err=%b id=0",
                               k, bus.resp_valid, bus.resp_data, bus.resp_carry, bus.resp_err, bus.resp_id, vd[k], vc[k], ve[k]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_op;
      logic [7:0] exp_data;
      logic       exp_err;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      exp_data = 8'h00;
      exp_err  = 1'b1;
`else
      exp_data = 8'h03;
      exp_err  = 1'b0;
`endif
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_req(0, 8'h01, 8'h02, (k == 0) ? 4'hE : 4'hF);
         bus.req_valid = 4'b0001;
         #1;
         checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL illegal_grant[%0d]: got %b expected 0001", k, bus.req_ready); end
         @(posedge clk); #1;
         bus.req_valid = '0;
         checks++; if (bus.resp_data !== exp_data || bus.resp_err !== exp_err || bus.resp_carry !== 1'b0) begin
            errors++; $display("FAIL illegal_resp[%0d]: got data=%h err=%b carry=%b expected data=%h err=%b carry=0",
                               k, bus.resp_data, bus.resp_err, bus.resp_carry, exp_data, exp_err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 4; i++) set_req(i, 8'h20, 8'h01, 4'h0);
      bus.resp_ready = 1'b0;
      bus.req_valid  = 4'b1000;
      #1;
      checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b expected 1000", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 4'hF;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3) begin
         errors++; $display("FAIL rmid_full: got v=%b id=%0d expected v=1 id=3", bus.resp_valid, bus.resp_id); end
      rst = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready_in_reset: got %b expected 0000", bus.req_ready); end
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 8'h00 || bus.resp_id !== 2'd0) begin
         errors++; $display("FAIL rmid_discard: got v=%b data=%h id=%0d expected v=0 data=00 id=0",
                            bus.resp_valid, bus.resp_data, bus.resp_id); end
      rst = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b expected 0001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 8'h21) begin
         errors++; $display("FAIL rmid_after: got v=%b id=%0d data=%h expected v=1 id=0 data=21",
                            bus.resp_valid, bus.resp_id, bus.resp_data); end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_alu_ops();
      test_illegal_op();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
